// File: rtl/aes_pkg.sv
// Shared AES types, FIPS-197 S-box tables and row-permutation helpers.
// Used by aes_last_round_de and aes_sbox_byte.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    typedef enum logic {
        MODE_DEC = 1'b0,
        MODE_ENC = 1'b1
    } aes_mode_e;

    localparam aes_byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam aes_byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Source byte index for output byte k (k = 4c + r, column-major).
    function automatic int unsigned shift_rows_src(input int unsigned k);
        int unsigned r;
        int unsigned c;
        r = k % 4;
        c = k / 4;
        return 4 * ((c + r) % 4) + r;
    endfunction

    function automatic int unsigned inv_shift_rows_src(input int unsigned k);
        int unsigned r;
        int unsigned c;
        r = k % 4;
        c = k / 4;
        return 4 * ((c + 4 - r) % 4) + r;
    endfunction

    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            o[127 - 8*k -: 8] = s[127 - 8*shift_rows_src(k) -: 8];
        end
        return o;
    endfunction

    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            o[127 - 8*k -: 8] = s[127 - 8*inv_shift_rows_src(k) -: 8];
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// Single-byte S-box lookup; inv=1 selects the inverse table.
// The forward table is only built when LASTROUND_ENC_EN is defined.
module aes_sbox_byte
    import aes_pkg::*;
(
    input  logic       inv,
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

`ifdef LASTROUND_ENC_EN
    assign out_byte = inv ? INV_SBOX[in_byte] : SBOX[in_byte];
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign out_byte   = INV_SBOX[in_byte];
`endif

endmodule

// File: rtl/aes_last_round_de.sv
// AES-128 last-round stage: decrypt (AddRoundKey, InvShiftRows, InvSubBytes)
// and, with LASTROUND_ENC_EN defined, the forward last round; one-cycle registered output.
module aes_last_round_de
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         n_rst,
    input  logic         encrypt,
    input  logic [127:0] keyword,
    input  logic [127:0] input_data,
    input  logic         data_valid,
    output logic [127:0] result,
    output logic         result_valid
);

    aes_mode_e  mode;
    aes_state_t dec_perm;
    aes_state_t sb_in;
    aes_state_t sb_out;
    aes_state_t round_out;
    aes_state_t result_d;
    aes_state_t result_q;
    logic       result_valid_d;
    logic       result_valid_q;

`ifdef LASTROUND_ENC_EN
    assign mode = aes_mode_e'(encrypt);
`else
    logic unused_encrypt;
    assign unused_encrypt = encrypt;
    assign mode           = MODE_DEC;
`endif

    // The 16 S-boxes are shared: decrypt feeds them the permuted key-mixed state,
    // encrypt feeds them the raw input.
    always_comb begin
        dec_perm = inv_shift_rows(input_data ^ keyword);
        sb_in    = (mode == MODE_ENC) ? input_data : dec_perm;
    end

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox_byte u_sbox (
            .inv      (mode == MODE_DEC),
            .in_byte  (sb_in[127 - 8*i -: 8]),
            .out_byte (sb_out[127 - 8*i -: 8])
        );
    end

`ifdef LASTROUND_ENC_EN
    assign round_out = (mode == MODE_ENC) ? (shift_rows(sb_out) ^ keyword) : sb_out;
`else
    assign round_out = sb_out;
`endif

    always_comb begin
        result_d       = data_valid ? round_out : result_q;
        result_valid_d = data_valid;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_aes_last_round_de.sv
// Bench for aes_last_round_de: GF(2^8)-derived S-box model plus FIPS-197 directed vectors.
// Build with or without LASTROUND_ENC_EN to match the RTL.
module tb_aes_last_round_de;

    logic         clk;
    logic         n_rst;
    logic         encrypt;
    logic [127:0] keyword;
    logic [127:0] input_data;
    logic         data_valid;
    logic [127:0] result;
    logic         result_valid;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] K_FIPS = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P_FIPS = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] ALL_52 = {16{8'h52}};
    localparam logic [127:0] ALL_63 = {16{8'h63}};

    aes_last_round_de dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .encrypt      (encrypt),
        .keyword      (keyword),
        .input_data   (input_data),
        .data_valid   (data_valid),
        .result       (result),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model: S-box from GF(2^8) inverse + affine map ----------------
    logic [7:0] m_sbox [256];
    logic [7:0] m_inv  [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            m_sbox[x] = s;
            m_inv[s]  = 8'(x);
        end
    endtask

    function automatic logic [7:0] get_b(input logic [127:0] st, input int k);
        return st[127 - 8*k -: 8];
    endfunction

    function automatic logic [127:0] model(input logic enc, input logic [127:0] key, input logic [127:0] din);
        logic [127:0] o;
        logic [127:0] t;
        int           src;
        o = '0;
        t = din ^ key;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (enc) begin
                    src = 4 * ((c + r) % 4) + r;
                    o[127 - 8*(4*c + r) -: 8] = m_sbox[get_b(din, src)] ^ get_b(key, 4*c + r);
                end else begin
                    src = 4 * ((c - r + 4) % 4) + r;
                    o[127 - 8*(4*c + r) -: 8] = m_inv[get_b(t, src)];
                end
            end
        end
        return o;
    endfunction

    function automatic logic eff_enc(input logic e);
`ifdef LASTROUND_ENC_EN
        return e;
`else
        return 1'b0 & e;
`endif
    endfunction

    logic [127:0] m_res;
    logic         m_vld;
    logic         cmp_en = 1'b0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_res <= '0;
            m_vld <= 1'b0;
        end else begin
            m_vld <= data_valid;
            if (data_valid) m_res <= model(eff_enc(encrypt), keyword, input_data);
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en && n_rst) begin
            check("cyc_valid", {127'b0, result_valid}, {127'b0, m_vld});
            check("cyc_result", result, m_res);
        end
    end

    task automatic step(input logic e, input logic [127:0] k, input logic [127:0] d, input logic v);
        @(negedge clk);
        encrypt    = e;
        keyword    = k;
        input_data = d;
        data_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_rst      = 1'b0;
        encrypt    = 1'b0;
        keyword    = '0;
        input_data = '0;
        data_valid = 1'b0;
        build_tables();

        // Pin the model with hand-known values
        check("model_sbox00", {120'b0, m_sbox[0]}, 128'h63);
        check("model_sbox53", {120'b0, m_sbox[8'h53]}, 128'hed);
        check("model_inv00", {120'b0, m_inv[0]}, 128'h52);
        check("model_fips_dec", model(1'b0, K_FIPS, C_FIPS), P_FIPS);
        check("model_fips_enc", model(1'b1, K_FIPS, P_FIPS), C_FIPS);

        #12;
        check("reset_result", result, '0);
        check("reset_valid", {127'b0, result_valid}, '0);

        @(negedge clk);
        #1 n_rst = 1'b1;
        cmp_en = 1'b1;

        // FIPS decrypt then zero decrypt back-to-back, then idle
        step(1'b0, K_FIPS, C_FIPS, 1'b1);
        check("fips_dec", result, P_FIPS);
        check("fips_dec_vld", {127'b0, result_valid}, 128'h1);
        step(1'b0, '0, '0, 1'b1);
        check("zero_dec", result, ALL_52);
        check("zero_dec_vld", {127'b0, result_valid}, 128'h1);
        step(1'b1, K_FIPS, 128'hdeadbeef, 1'b0);
        check("hold_result", result, ALL_52);
        check("hold_vld", {127'b0, result_valid}, 128'h0);

`ifdef LASTROUND_ENC_EN
        step(1'b1, K_FIPS, P_FIPS, 1'b1);
        check("fips_enc", result, C_FIPS);
        step(1'b1, '0, '0, 1'b1);
        check("zero_enc", result, ALL_63);
`else
        step(1'b1, K_FIPS, C_FIPS, 1'b1);
        check("enc_ignored", result, P_FIPS);
        step(1'b1, '0, '0, 1'b1);
        check("zero_enc_ignored", result, ALL_52);
`endif

        // Asynchronous reset while result_valid is high
        step(1'b0, K_FIPS, C_FIPS, 1'b1);
        check("pre_reset_vld", {127'b0, result_valid}, 128'h1);
        #2 n_rst = 1'b0;
        #1;
        check("async_rst_result", result, '0);
        check("async_rst_vld", {127'b0, result_valid}, '0);
        @(negedge clk);
        #1 n_rst = 1'b1;
        step(1'b0, K_FIPS, C_FIPS, 1'b1);
        check("post_reset_dec", result, P_FIPS);
        check("post_reset_vld", {127'b0, result_valid}, 128'h1);

        // Assorted vectors with mode, key and valid varying every cycle
        for (int i = 0; i < 24; i++) begin
            step(1'($urandom_range(0, 1)),
                 {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 3) != 0));
        end
        step(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_last_round_de.md
# aes_last_round_de

Single-round AES-128 datapath stage that strips the final encryption round from a 128-bit state. In decrypt mode it applies AddRoundKey, then InvShiftRows, then InvSubBytes (FIPS-197 inverse-cipher round-1 order). In encrypt mode it applies the forward last round. It sits at the head of the decryption round pipeline, fed by the ciphertext and the round-10 key from the key schedule. The output is registered with a one-cycle valid handshake.

## Interface
- No parameters.
- `clk`  input  1  rising-edge clock.
- `n_rst`  input  1  asynchronous, active-low reset.
- `encrypt`  input  1  mode select: 0 = decrypt last round, 1 = forward last round (only when `LASTROUND_ENC_EN` is defined).
- `keyword`  input  128  round key (round 10 for AES-128).
- `input_data`  input  128  state in.
- `data_valid`  input  1  qualifies `input_data`, `keyword` and `encrypt` this cycle.
- `result`  output  128  registered state out.
- `result_valid`  output  1  high for one cycle when `result` holds a new value.

## Operation
- **State layout (FIPS-197, column-major):**
  - byte k = bits [127-8k -: 8].
  - Row r, column c is byte 4c+r.
- **Decrypt (`encrypt`=0):**
  - t = `input_data` XOR `keyword`.
  - u = InvShiftRows(t): row r rotates right by r columns, so u[r][c] = t[r][(c-r) mod 4].
  - result = InvSBox applied to every byte of u.
- **Encrypt (`encrypt`=1, macro defined):**
  - v = SBox applied to every byte of `input_data`.
  - w = ShiftRows(v): w[r][c] = v[r][(c+r) mod 4].
  - result = w XOR `keyword`.
- The two modes are exact inverses for the same `keyword`.
- S-box tables are the standard FIPS-197 tables, implemented combinationally.
- No internal state other than the output registers.

## Timing
- Reset (`n_rst` low, asynchronous) clears `result` to 128'h0 and `result_valid` to 0 immediately. Reset mid-operation discards the in-flight value.
- Latency: 1 cycle. Inputs sampled on rising edge N with `data_valid`=1 appear on `result` with `result_valid`=1 after edge N.
- When `data_valid`=0 at an edge:
  - `result` holds its previous value.
  - `result_valid` is 0 in the following cycle.
- Full throughput: a new input is accepted every cycle. Back-to-back valid inputs give back-to-back valid outputs.
- There is no backpressure; the consumer must take `result` while `result_valid`=1.
- `encrypt` and `keyword` may change every cycle. Only the values sampled with `data_valid`=1 matter.

## Configuration
- Macro: `LASTROUND_ENC_EN`.
- **Defined:**
  - The forward path (SBox, ShiftRows, XOR) is compiled in.
  - `encrypt` selects the mode as described above.
- **Undefined:**
  - Only the decrypt path and the inverse S-box are built.
  - The `encrypt` port remains but is ignored; the block always decrypts.
  - The forward S-box table is not instantiated.

## Structure
- Shared package `aes_pkg` contains:
  - `aes_state_t`: 128-bit state typedef.
  - `aes_byte_t`: 8-bit byte typedef.
  - `SBOX` and `INV_SBOX`: 256-entry byte constant arrays.
  - Functions for ShiftRows and InvShiftRows index mapping.
- Sub-module `aes_sbox_byte`:
  - Ports: one byte in, one byte out, plus an `inv` select.
  - Instantiated 16 times.
  - Its forward half exists only under `LASTROUND_ENC_EN`.
- The top level holds the XOR, the row permutations, the mode mux and the output registers.

## Test plan
- **FIPS decrypt vector.**
  - Stimulus: `encrypt`=0, `keyword`=13111d7fe3944a17f307a78b4d2b30c5, `input_data`=69c4e0d86a7b0430d8cdb78070b4c55a, `data_valid`=1.
  - Response one cycle later: `result`=bd6e7c3df2b5779e0b61216e8b10b689, `result_valid`=1.
- **FIPS encrypt vector (macro defined).**
  - Stimulus: `encrypt`=1, same key, `input_data`=bd6e7c3df2b5779e0b61216e8b10b689.
  - Response: `result`=69c4e0d86a7b0430d8cdb78070b4c55a.
- **Zero vectors.**
  - Zero key, zero data, `encrypt`=0 → `result`=52 repeated in all 16 bytes.
  - Zero key, zero data, `encrypt`=1 → `result`=63 repeated in all 16 bytes.
- **Back-to-back.**
  - Stimulus: the decrypt vector then the zero-decrypt vector on consecutive cycles.
  - Response: both results on consecutive cycles, `result_valid` high for 2 cycles.
  - Then drop `data_valid`: `result` holds 5252…52 and `result_valid` goes to 0.
- **Reset.**
  - Assert `n_rst` low between clock edges while `result_valid`=1.
  - `result` becomes 0 and `result_valid` becomes 0 immediately, without waiting for a clock edge.
  - After release, the first valid input produces its correct output one cycle later.
- **Macro undefined build.**
  - Stimulus: `encrypt`=1 with the FIPS ciphertext and key.
  - Response: `result`=bd6e7c3df2b5779e0b61216e8b10b689, i.e. the decrypt path.
